// File: rtl/bank_sc.sv
// Bank storage controller: accepts issue-unit requests, merges linefill
// writes into a 64 x 256-bit line array under per-sub-word dirty masks,
// and returns read data through a single-entry registered response stage.
module bank_sc (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         isu_sc_valid_i,
    output logic         isu_sc_ready_o,
    input  logic [1:0]   isu_sc_channel_id_i,
    input  logic [2:0]   isu_sc_opcode_i,
    input  logic [6:0]   isu_sc_set_way_offset_i,
    input  logic [7:0]   isu_sc_wbuffer_id_i,
    input  logic [2:0]   isu_sc_xbar_rob_num_i,
    input  logic [1:0]   isu_sc_cacheline_dirty_offset0_i,
    input  logic [1:0]   isu_sc_cacheline_dirty_offset1_i,
    input  logic [127:0] isu_sc_linefill_data_offset0_i,
    input  logic [127:0] isu_sc_linefill_data_offset1_i,
    output logic         sc_rsp_valid_o,
    input  logic         sc_rsp_ready_i,
    output logic [1:0]   sc_rsp_channel_id_o,
    output logic [7:0]   sc_rsp_wbuffer_id_o,
    output logic [2:0]   sc_rsp_xbar_rob_num_o,
    output logic [127:0] sc_rsp_data_offset0_o,
    output logic [127:0] sc_rsp_data_offset1_o,
    output logic         sc_err_o
);

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;

    // Merge a linefill into a stored line: a set dirty bit protects its
    // 64-bit sub-word, a clear one lets the incoming data overwrite it.
    // dirty[1:0] covers line bits [127:0], dirty[3:2] covers [255:128].
    function automatic logic [255:0] merge_line(
        input logic [255:0] old_line,
        input logic [255:0] new_line,
        input logic [3:0]   dirty
    );
        logic [255:0] res;
        res = old_line;
        for (int k = 0; k < 4; k++) begin
            if (dirty[k]) begin
                res[k*64 +: 64] = old_line[k*64 +: 64];
            end else begin
                res[k*64 +: 64] = new_line[k*64 +: 64];
            end
        end
        return res;
    endfunction

    logic [255:0] mem_r [0:63];

    logic         rsp_valid_r;
    logic [1:0]   rsp_channel_r;
    logic [7:0]   rsp_wbuffer_r;
    logic [2:0]   rsp_rob_r;
    logic [255:0] rsp_data_r;
    logic         err_r;

    logic         hs_s;
    logic [5:0]   line_s;
    logic         wr_s;
    logic         rd_s;
    logic         bad_req_s;
    logic [255:0] merged_s;

    // Ready depends only on the response stage so writes also stall under backpressure.
    assign isu_sc_ready_o = !rsp_valid_r || sc_rsp_ready_i;
    assign hs_s      = isu_sc_valid_i && isu_sc_ready_o;
    assign line_s    = isu_sc_set_way_offset_i[6:1];
    assign wr_s      = hs_s && (isu_sc_opcode_i == OP_WRITE);
    assign rd_s      = hs_s && (isu_sc_opcode_i == OP_READ);
    assign bad_req_s = hs_s && ((isu_sc_opcode_i > OP_READ) || isu_sc_set_way_offset_i[0]);
    assign merged_s  = merge_line(mem_r[line_s],
                                  {isu_sc_linefill_data_offset1_i, isu_sc_linefill_data_offset0_i},
                                  {isu_sc_cacheline_dirty_offset1_i, isu_sc_cacheline_dirty_offset0_i});

    // Line array: cleared on reset, merged write at the handshake edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 64; i++) begin
                mem_r[i] <= 256'd0;
            end
        end else if (wr_s) begin
            mem_r[line_s] <= merged_s;
        end
    end

    // Response stage: a read loads it (replacing a popped entry), a pop without a read empties it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_r   <= 1'b0;
            rsp_channel_r <= 2'd0;
            rsp_wbuffer_r <= 8'd0;
            rsp_rob_r     <= 3'd0;
            rsp_data_r    <= 256'd0;
        end else if (rd_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_channel_r <= isu_sc_channel_id_i;
            rsp_wbuffer_r <= isu_sc_wbuffer_id_i;
            rsp_rob_r     <= isu_sc_xbar_rob_num_i;
            rsp_data_r    <= mem_r[line_s];
        end else if (sc_rsp_ready_i) begin
            rsp_valid_r   <= 1'b0;
        end
    end

    // Sticky error flag for reserved opcodes and misaligned offsets; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (bad_req_s) begin
            err_r <= 1'b1;
        end
    end

    assign sc_rsp_valid_o        = rsp_valid_r;
    assign sc_rsp_channel_id_o   = rsp_channel_r;
    assign sc_rsp_wbuffer_id_o   = rsp_wbuffer_r;
    assign sc_rsp_xbar_rob_num_o = rsp_rob_r;
    assign sc_rsp_data_offset0_o = rsp_data_r[127:0];
    assign sc_rsp_data_offset1_o = rsp_data_r[255:128];
    assign sc_err_o              = err_r;

endmodule

// File: tb/tb_bank_sc.sv
// Directed testbench for bank_sc: hand-computed expectations checked with
// immediate assertions after each step.
module tb_bank_sc;

    logic         clk;
    logic         rst;
    logic         valid;
    logic         ready;
    logic [1:0]   channel;
    logic [2:0]   opcode;
    logic [6:0]   offset;
    logic [7:0]   wbuf;
    logic [2:0]   rob;
    logic [1:0]   dirty0;
    logic [1:0]   dirty1;
    logic [127:0] data0;
    logic [127:0] data1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_channel;
    logic [7:0]   rsp_wbuf;
    logic [2:0]   rsp_rob;
    logic [127:0] rsp_data0;
    logic [127:0] rsp_data1;
    logic         err;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] LO_F = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [127:0] HI_F = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

    bank_sc dut (
        .clk_i                            (clk),
        .rst_i                            (rst),
        .isu_sc_valid_i                   (valid),
        .isu_sc_ready_o                   (ready),
        .isu_sc_channel_id_i              (channel),
        .isu_sc_opcode_i                  (opcode),
        .isu_sc_set_way_offset_i          (offset),
        .isu_sc_wbuffer_id_i              (wbuf),
        .isu_sc_xbar_rob_num_i            (rob),
        .isu_sc_cacheline_dirty_offset0_i (dirty0),
        .isu_sc_cacheline_dirty_offset1_i (dirty1),
        .isu_sc_linefill_data_offset0_i   (data0),
        .isu_sc_linefill_data_offset1_i   (data1),
        .sc_rsp_valid_o                   (rsp_valid),
        .sc_rsp_ready_i                   (rsp_ready),
        .sc_rsp_channel_id_o              (rsp_channel),
        .sc_rsp_wbuffer_id_o              (rsp_wbuf),
        .sc_rsp_xbar_rob_num_o            (rsp_rob),
        .sc_rsp_data_offset0_o            (rsp_data0),
        .sc_rsp_data_offset1_o            (rsp_data1),
        .sc_err_o                         (err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for one clock edge, then drop valid (#1 after the edge).
    task automatic req(input logic [2:0] op, input logic [6:0] off,
                       input logic [1:0] dm0, input logic [1:0] dm1,
                       input logic [127:0] d0, input logic [127:0] d1,
                       input logic [1:0] ch, input logic [7:0] wb, input logic [2:0] rb);
        valid   = 1'b1;
        opcode  = op;
        offset  = off;
        dirty0  = dm0;
        dirty1  = dm1;
        data0   = d0;
        data1   = d1;
        channel = ch;
        wbuf    = wb;
        rob     = rb;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; rsp_ready = 1'b1;
        channel = 2'd0; opcode = 3'd0; offset = 7'd0; wbuf = 8'd0; rob = 3'd0;
        dirty0 = 2'd0; dirty1 = 2'd0; data0 = 128'd0; data1 = 128'd0;
        #12;
        chk("reset_valid", 256'(rsp_valid), 256'(1'b0));
        chk("reset_err",   256'(err),       256'(1'b0));
        chk("reset_ready", 256'(ready),     256'(1'b1));
        chk("reset_data0", 256'(rsp_data0), 256'(128'd0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Read of an untouched line returns zeros with echoed tags.
        req(3'd1, 7'd10, 2'd0, 2'd0, 128'd0, 128'd0, 2'd2, 8'h11, 3'd3);
        chk("rd5_valid", 256'(rsp_valid),   256'(1'b1));
        chk("rd5_data0", 256'(rsp_data0),   256'(128'd0));
        chk("rd5_data1", 256'(rsp_data1),   256'(128'd0));
        chk("rd5_rob",   256'(rsp_rob),     256'(3'd3));
        chk("rd5_chan",  256'(rsp_channel), 256'(2'd2));
        chk("rd5_wbuf",  256'(rsp_wbuf),    256'(8'h11));
        chk("rd5_err",   256'(err),         256'(1'b0));

        // Full write to line 0 then an immediate read.
        req(3'd0, 7'd0, 2'd0, 2'd0, 128'd100, 128'd101, 2'd0, 8'h00, 3'd0);
        chk("wr0_no_rsp", 256'(rsp_valid), 256'(1'b0));
        req(3'd1, 7'd0, 2'd0, 2'd0, 128'd0, 128'd0, 2'd1, 8'h22, 3'd4);
        chk("rd0_data0", 256'(rsp_data0), 256'(128'd100));
        chk("rd0_data1", 256'(rsp_data1), 256'(128'd101));

        // Dirty-mask merge on line 1.
        req(3'd0, 7'd2, 2'd0, 2'd0, ONES, ONES, 2'd0, 8'h00, 3'd0);
        req(3'd0, 7'd2, 2'b01, 2'b10, 128'd0, 128'd0, 2'd0, 8'h00, 3'd0);
        req(3'd1, 7'd2, 2'd0, 2'd0, 128'd0, 128'd0, 2'd0, 8'h33, 3'd5);
        chk("merge_data0", 256'(rsp_data0), 256'(LO_F));
        chk("merge_data1", 256'(rsp_data1), 256'(HI_F));
        @(posedge clk); #1;
        chk("pop_valid", 256'(rsp_valid), 256'(1'b0));

        // Backpressure: two reads, response stalls for three cycles.
        rsp_ready = 1'b0;
        req(3'd1, 7'd0, 2'd0, 2'd0, 128'd0, 128'd0, 2'd1, 8'hA1, 3'd1);
        valid = 1'b1; opcode = 3'd1; offset = 7'd2; rob = 3'd2; wbuf = 8'hA2;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_ready", 256'(ready),     256'(1'b0));
            chk("bp_valid", 256'(rsp_valid), 256'(1'b1));
            chk("bp_rob",   256'(rsp_rob),   256'(3'd1));
            chk("bp_data0", 256'(rsp_data0), 256'(128'd100));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 256'(ready), 256'(1'b1));
        @(posedge clk); #1;
        valid = 1'b0;
        chk("bp_second_valid", 256'(rsp_valid), 256'(1'b1));
        chk("bp_second_rob",   256'(rsp_rob),   256'(3'd2));
        chk("bp_second_wbuf",  256'(rsp_wbuf),  256'(8'hA2));
        chk("bp_second_data0", 256'(rsp_data0), 256'(LO_F));
        @(posedge clk); #1;
        chk("bp_drained", 256'(rsp_valid), 256'(1'b0));

        // Reserved opcode: dropped, error set, line 2 unchanged.
        req(3'd5, 7'd4, 2'd0, 2'd0, ONES, ONES, 2'd0, 8'h00, 3'd0);
        chk("rsv_no_rsp", 256'(rsp_valid), 256'(1'b0));
        chk("rsv_err",    256'(err),       256'(1'b1));
        req(3'd1, 7'd4, 2'd0, 2'd0, 128'd0, 128'd0, 2'd0, 8'h00, 3'd0);
        chk("rsv_line2_data0", 256'(rsp_data0), 256'(128'd0));
        chk("rsv_line2_data1", 256'(rsp_data1), 256'(128'd0));
        @(posedge clk); #1;
        chk("rsv_err_sticky", 256'(err), 256'(1'b1));

        // Asynchronous reset with a pending response.
        rsp_ready = 1'b0;
        req(3'd1, 7'd0, 2'd0, 2'd0, 128'd0, 128'd0, 2'd3, 8'h44, 3'd6);
        chk("pre_rst_valid", 256'(rsp_valid), 256'(1'b1));
        #1; rst = 1'b1; #1;
        chk("rst_valid", 256'(rsp_valid), 256'(1'b0));
        chk("rst_err",   256'(err),       256'(1'b0));
        chk("rst_data0", 256'(rsp_data0), 256'(128'd0));
        rsp_ready = 1'b1;
        #1; rst = 1'b0;
        @(posedge clk); #1;
        req(3'd1, 7'd0, 2'd0, 2'd0, 128'd0, 128'd0, 2'd0, 8'h00, 3'd0);
        chk("post_rst_line0_data0", 256'(rsp_data0), 256'(128'd0));
        chk("post_rst_line0_data1", 256'(rsp_data1), 256'(128'd0));

        // Misaligned offset (bit 0 set) flags the error; all-dirty write leaves line 1 intact.
        req(3'd0, 7'd3, 2'b11, 2'b11, ONES, ONES, 2'd0, 8'h00, 3'd0);
        chk("mis_no_rsp", 256'(rsp_valid), 256'(1'b0));
        chk("mis_err",    256'(err),       256'(1'b1));
        req(3'd1, 7'd2, 2'd0, 2'd0, 128'd0, 128'd0, 2'd0, 8'h00, 3'd0);
        chk("post_rst_line1_data0", 256'(rsp_data0), 256'(128'd0));
        chk("post_rst_line1_data1", 256'(rsp_data1), 256'(128'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
